// File: rtl/coco_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : coco_uart_tx
// Function : Memory-mapped 8N1 UART transmitter with programmable bit period
//            and a level interrupt. Define COCO_UART_FIFO_EN for a DEPTH-entry
//            TX FIFO; otherwise a single holding register buffers the byte.
// Revision : 1.0 - initial release
// ============================================================================
module coco_uart_tx #(
    parameter int          DEPTH     = 4,
    parameter logic [15:0] DIV_RESET = 16'd434
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [1:0]  A,
    input  logic        We,
    input  logic [31:0] Din,
    output logic [31:0] DOut,
    output logic        TxD,
    output logic        Out
);

    localparam logic [1:0] c_addr_ctrl   = 2'd0;
    localparam logic [1:0] c_addr_baud   = 2'd1;
    localparam logic [1:0] c_addr_txdata = 2'd2;
    localparam logic [1:0] c_addr_status = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t      r_state, w_state_nxt;
    logic        r_en, r_ie, r_ovf, r_txd, r_out;
    logic [15:0] r_div, r_baud_cnt;
    logic [7:0]  r_shift;
    logic [2:0]  r_bit_cnt;

    logic        w_push, w_push_ok, w_pop, w_empty, w_full, w_tick, w_busy;
    logic [7:0]  w_head;
    logic [3:0]  w_count;
    logic [15:0] w_period;
    logic        w_unused;

    assign w_push   = We && (A == c_addr_txdata);
    assign w_period = (r_div < 16'd2) ? 16'd2 : r_div;
    assign w_tick   = (r_baud_cnt == 16'd1);
    assign w_busy   = (r_state != ST_IDLE);

`ifdef COCO_UART_FIFO_EN
    localparam int               c_ptr_w    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_ptr_w-1:0] c_ptr_last = c_ptr_w'(DEPTH - 1);
    localparam logic [3:0]       c_depth    = 4'(DEPTH);

    logic [7:0]         r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr, r_rd_ptr;
    logic [3:0]         r_count;

    assign w_empty   = (r_count == 4'd0);
    assign w_full    = (r_count == c_depth);
    // A pop in the same cycle frees the slot a full-FIFO push needs.
    assign w_push_ok = w_push && (!w_full || w_pop);
    assign w_head    = r_mem[r_rd_ptr];
    assign w_count   = r_count;
    assign w_unused  = ^Din[31:16];

    always_ff @(posedge Clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= Din[7:0];
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= 4'd0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= (r_wr_ptr == c_ptr_last) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_ptr_last) ? '0 : r_rd_ptr + 1'b1;
            end
            if (w_push_ok && !w_pop) begin
                r_count <= r_count + 4'd1;
            end else if (w_pop && !w_push_ok) begin
                r_count <= r_count - 4'd1;
            end
        end
    end
`else
    logic [7:0] r_hold;
    logic       r_valid;

    assign w_empty   = !r_valid;
    assign w_full    = r_valid;
    assign w_push_ok = w_push && (!r_valid || w_pop);
    assign w_head    = r_hold;
    assign w_count   = {3'b000, r_valid};
    assign w_unused  = ^{Din[31:16], (DEPTH != 0)};

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_hold  <= 8'h00;
            r_valid <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_hold  <= Din[7:0];
                r_valid <= 1'b1;
            end else if (w_pop) begin
                r_valid <= 1'b0;
            end
        end
    end
`endif

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_en && !w_empty) begin
                    w_state_nxt = ST_START;
                    w_pop       = 1'b1;
                end
            end
            ST_START: begin
                if (w_tick) w_state_nxt = ST_DATA;
            end
            ST_DATA: begin
                if (w_tick && (r_bit_cnt == 3'd7)) w_state_nxt = ST_STOP;
            end
            ST_STOP: begin
                // Chain straight into the next start bit when data is waiting.
                if (w_tick) begin
                    if (r_en && !w_empty) begin
                        w_state_nxt = ST_START;
                        w_pop       = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_shift    <= 8'h00;
            r_bit_cnt  <= 3'd0;
            r_baud_cnt <= 16'd0;
            r_txd      <= 1'b1;
        end else if (w_pop) begin
            r_shift    <= w_head;
            r_bit_cnt  <= 3'd0;
            r_baud_cnt <= w_period;
            r_txd      <= 1'b0;
        end else if (r_state != ST_IDLE) begin
            if (w_tick) begin
                r_baud_cnt <= w_period;
                case (r_state)
                    ST_START: begin
                        r_txd     <= r_shift[0];
                        r_bit_cnt <= 3'd0;
                    end
                    ST_DATA: begin
                        if (r_bit_cnt == 3'd7) begin
                            r_txd <= 1'b1;
                        end else begin
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_txd     <= r_shift[1];
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end
                    default: r_txd <= 1'b1;
                endcase
            end else begin
                r_baud_cnt <= r_baud_cnt - 16'd1;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_en  <= 1'b0;
            r_ie  <= 1'b0;
            r_div <= DIV_RESET;
            r_ovf <= 1'b0;
            r_out <= 1'b0;
        end else begin
            if (We && (A == c_addr_ctrl)) begin
                r_en <= Din[0];
                r_ie <= Din[1];
            end
            if (We && (A == c_addr_baud)) begin
                r_div <= Din[15:0];
            end
            if (We && (A == c_addr_status)) begin
                r_ovf <= 1'b0;
            end else if (w_push && !w_push_ok) begin
                r_ovf <= 1'b1;
            end
            r_out <= r_ie && w_empty && (r_state == ST_IDLE);
        end
    end

    always_comb begin
        DOut = 32'h0;
        case (A)
            c_addr_ctrl:   DOut = {30'h0, r_ie, r_en};
            c_addr_baud:   DOut = {16'h0, r_div};
            c_addr_status: DOut = {24'h0, w_count, r_ovf, w_empty, w_full, w_busy};
            default:       DOut = 32'h0;
        endcase
    end

    assign TxD = r_txd;
    assign Out = r_out;

endmodule
`default_nettype wire

// File: tb/tb_coco_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_coco_uart_tx
// Function : Scoreboard bench for coco_uart_tx; a serial monitor checks each
//            frame against queued expectations. Honours COCO_UART_FIFO_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_coco_uart_tx;

`ifdef COCO_UART_FIFO_EN
    localparam int          c_nfill = 4;
    localparam logic [31:0] c_one_q = 32'h10;
`else
    localparam int          c_nfill = 1;
    localparam logic [31:0] c_one_q = 32'h12;
`endif
    localparam logic [31:0] c_ovf     = 32'(c_nfill << 4) | 32'hA;
    localparam logic [31:0] c_fullq   = 32'(c_nfill << 4) | 32'h2;
    localparam logic [31:0] c_pushpop = 32'(c_nfill << 4) | 32'h3;

    typedef struct packed {
        logic [7:0]       data;
        logic [9:0][15:0] per;
        logic [31:0]      start;
    } exp_t;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [1:0]  A = 2'd0;
    logic        We = 1'b0;
    logic [31:0] Din = 32'h0;
    logic [31:0] DOut;
    logic        TxD, Out;

    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;
    logic mon_en = 1'b0;
    logic mon_busy = 1'b0;
    exp_t sb[$];

    coco_uart_tx #(.DEPTH(4), .DIV_RESET(16'd434)) dut (
        .Clk(Clk), .Reset(Reset), .A(A), .We(We), .Din(Din),
        .DOut(DOut), .TxD(TxD), .Out(Out)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] d, input int p, input int s);
        exp_t e;
        e.data = d;
        for (int i = 0; i < 10; i++) e.per[i] = 16'(p);
        e.start = 32'(s);
        return e;
    endfunction

    // Write is captured on the posedge between two negedges; t is that edge.
    task automatic wr(input logic [1:0] a, input logic [31:0] d, output int t);
        @(negedge Clk);
        A = a; Din = d; We = 1'b1;
        @(negedge Clk);
        We = 1'b0;
        t = cyc;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        A = a;
        #1;
        d = DOut;
    endtask

    task automatic wait_until(input int c);
        for (int k = 0; k < 100000 && cyc < c; k++) @(negedge Clk);
    endtask

    task automatic drain();
        for (int k = 0; k < 5000; k++) begin
            if (sb.size() == 0 && !mon_busy) break;
            @(negedge Clk);
        end
        chk("drain", 32'(sb.size() == 0 && !mon_busy), 32'd1);
    endtask

    // Serial monitor: every cycle of every bit must hold the expected level.
    exp_t       m_e;
    int         m_bad, m_st;
    logic [7:0] m_rx;
    logic       m_bit;
    initial begin
        forever begin
            @(negedge Clk);
            if (mon_en && TxD === 1'b0) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL unexpected_frame: start bit at cycle %0d, none queued", cyc);
                    for (int k = 0; k < 20000 && TxD !== 1'b1; k++) @(negedge Clk);
                end else begin
                    mon_busy = 1'b1;
                    m_e  = sb.pop_front();
                    m_st = cyc;
                    m_bad = 0;
                    m_rx = 8'h00;
                    for (int b = 0; b < 10; b++) begin
                        for (int c = 0; c < int'(m_e.per[b]); c++) begin
                            if (b != 0 || c != 0) @(negedge Clk);
                            m_bit = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : m_e.data[b-1];
                            if (TxD !== m_bit) m_bad++;
                            if (b >= 1 && b <= 8 && c == int'(m_e.per[b]) / 2) m_rx[b-1] = TxD;
                        end
                    end
                    chk("frame(bad_samples,byte)", {m_bad[23:0], m_rx}, {24'd0, m_e.data});
                    if (m_e.start != 32'hFFFF_FFFF) chk("frame_start", 32'(m_st), m_e.start);
                    mon_busy = 1'b0;
                end
            end
        end
    end

    initial begin
        int          t, n, m;
        logic [31:0] d;
        exp_t        e;

        #3 Reset = 1'b0;
        repeat (3) @(negedge Clk);
        chk("rst_txd", 32'(TxD), 32'd1);
        chk("rst_out", 32'(Out), 32'd0);
        rd(2'd1, d); chk("rst_baud", d, 32'd434);
        rd(2'd3, d); chk("rst_status", d, 32'h4);
        rd(2'd0, d); chk("rst_ctrl", d, 32'h0);
        rd(2'd2, d); chk("rst_txdata", d, 32'h0);
        @(negedge Clk);
        Reset = 1'b1;
        mon_en = 1'b1;

        // Single frame, BAUD=4
        wr(2'd1, 32'd4, t);
        wr(2'd0, 32'd1, t);
        wr(2'd2, 32'h55, n);
        sb.push_back(mk(8'h55, 4, n + 1));
        rd(2'd3, d); chk("t1_queued", d, c_one_q);
        wait_until(n + 1);  rd(2'd3, d); chk("t1_busy_first", d, 32'h5);
        wait_until(n + 40); rd(2'd3, d); chk("t1_busy_last", d, 32'h5);
        wait_until(n + 41); rd(2'd3, d); chk("t1_idle", d, 32'h4);
        drain();

        // Back-to-back frames, BAUD=2
        wr(2'd0, 32'd0, t);
        wr(2'd1, 32'd2, t);
`ifdef COCO_UART_FIFO_EN
        wr(2'd2, 32'hA1, t);
        wr(2'd2, 32'hB2, t);
        wr(2'd2, 32'hC3, t);
        rd(2'd3, d); chk("t2_count3", d, 32'h30);
        wr(2'd0, 32'd1, m);
        sb.push_back(mk(8'hA1, 2, m + 1));
        sb.push_back(mk(8'hB2, 2, m + 21));
        sb.push_back(mk(8'hC3, 2, m + 41));
        wait_until(m + 1);  rd(2'd3, d); chk("t2_count2", d, 32'h21);
        wait_until(m + 21); rd(2'd3, d); chk("t2_count1", d, 32'h11);
`else
        wr(2'd2, 32'hA1, t);
        wr(2'd0, 32'd1, m);
        sb.push_back(mk(8'hA1, 2, m + 1));
        wr(2'd2, 32'hB2, t);
        sb.push_back(mk(8'hB2, 2, m + 21));
        wait_until(m + 22);
        wr(2'd2, 32'hC3, t);
        sb.push_back(mk(8'hC3, 2, m + 41));
`endif
        wait_until(m + 41); rd(2'd3, d); chk("t2_count0", d, 32'h05);
        wait_until(m + 61); rd(2'd3, d); chk("t2_idle", d, 32'h04);
        drain();

        // Overflow, STATUS clear, then simultaneous push+pop while full
        wr(2'd0, 32'd0, t);
        for (int i = 1; i <= c_nfill + 1; i++) wr(2'd2, 32'(i), t);
        rd(2'd3, d); chk("t3_ovf", d, c_ovf);
        wr(2'd3, 32'd0, t);
        rd(2'd3, d); chk("t3_ovf_clr", d, c_fullq);
        wr(2'd0, 32'd1, m);
        A = 2'd2; Din = 32'h06; We = 1'b1;
        for (int i = 0; i < c_nfill; i++) sb.push_back(mk(8'(i + 1), 2, m + 1 + 20 * i));
        sb.push_back(mk(8'h06, 2, m + 1 + 20 * c_nfill));
        @(negedge Clk);
        We = 1'b0;
        rd(2'd3, d); chk("t3_pushpop_full", d, c_pushpop);
        drain();

        // Interrupt
        wr(2'd0, 32'd3, t);
        wait_until(t + 2); chk("t4_out_idle", 32'(Out), 32'd1);
        wr(2'd2, 32'hFF, n);
        sb.push_back(mk(8'hFF, 2, n + 1));
        wait_until(n + 1);  chk("t4_out_drop", 32'(Out), 32'd0);
        wait_until(n + 21); chk("t4_out_low_at_idle", 32'(Out), 32'd0);
        wait_until(n + 22); chk("t4_out_rise", 32'(Out), 32'd1);
        wr(2'd0, 32'd1, t);
        wait_until(t + 1);  chk("t4_out_ie_off", 32'(Out), 32'd0);
        drain();

        // EN cleared during the 3rd data bit
        wr(2'd1, 32'd4, t);
        wr(2'd2, 32'h3C, n);
        sb.push_back(mk(8'h3C, 4, n + 1));
        wr(2'd2, 32'h5A, t);
        wait_until(n + 12);
        wr(2'd0, 32'd0, t);
        wait_until(n + 42); rd(2'd3, d); chk("t5_idle_queued", d, c_one_q);
        repeat (60) @(negedge Clk);
        rd(2'd3, d); chk("t5_still_queued", d, c_one_q);
        wr(2'd0, 32'd1, m);
        sb.push_back(mk(8'h5A, 4, m + 1));
        drain();

        // BAUD 4 -> 8 written during data bit 0
        wr(2'd2, 32'hC5, n);
        e = mk(8'hC5, 8, n + 1);
        e.per[0] = 16'd4;
        e.per[1] = 16'd4;
        sb.push_back(e);
        wait_until(n + 4);
        wr(2'd1, 32'd8, t);
        drain();

        // DIV=0 clamps to a 2-cycle bit
        wr(2'd1, 32'd0, t);
        rd(2'd1, d); chk("t6_baud0_rb", d, 32'd0);
        wr(2'd2, 32'h96, n);
        sb.push_back(mk(8'h96, 2, n + 1));
        drain();

        // Reset pulse mid-frame
        mon_en = 1'b0;
        wr(2'd1, 32'd4, t);
        wr(2'd2, 32'h00, n);
        wr(2'd2, 32'h11, t);
        wait_until(n + 3); chk("t7_txd_start", 32'(TxD), 32'd0);
        #2 Reset = 1'b0;
        #1 chk("t7_txd_async", 32'(TxD), 32'd1);
        rd(2'd3, d); chk("t7_status", d, 32'h4);
        rd(2'd1, d); chk("t7_baud", d, 32'd434);
        @(negedge Clk);
        Reset = 1'b1;
        mon_en = 1'b1;
        repeat (5) @(negedge Clk);
        chk("t7_txd_idle", 32'(TxD), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/coco_uart_tx.md
# coco_uart_tx

Memory-mapped UART transmitter peripheral on the system bridge, alongside the timer and LED register. The CPU writes bytes through the bridge's 2-bit word-addressed device port. The block buffers the bytes and serialises them on `TxD` as 8N1 frames at a programmable bit period. Its level interrupt `Out` feeds one of the CPU's hardware-interrupt inputs next to the timer's.

## Interface
- `DEPTH`, default 4: TX FIFO entries, 2..15. Ignored without the FIFO macro.
- `DIV_RESET`, default 16'd434: reset value of the BAUD register, in clock cycles per bit.
- `Clk` in 1: system clock; all state changes on its rising edge.
- `Reset` in 1: asynchronous, active-low reset; while 0, all state is held at reset values.
- `A` in 2: register word select. 0=CTRL, 1=BAUD, 2=TXDATA, 3=STATUS.
- `We` in 1: write strobe from the bridge; the write is captured at the `Clk` edge.
- `Din` in 32: write data.
- `DOut` out 32: read data; combinational from `A`.
- `TxD` out 1: serial line, registered; idles at 1.
- `Out` out 1: level interrupt, registered.

## Operation
- **CTRL** (R/W): bit0 EN, bit1 IE; other bits read 0. Reset value 0.
- **BAUD** (R/W): bits[15:0] DIV; other bits read 0. Reset value `DIV_RESET`.
  - Effective bit period = max(DIV, 2) cycles.
- **TXDATA** (W): a write pushes `Din[7:0]` into the FIFO. Reads return 0.
- **STATUS** (R): bit0 BUSY (state ≠ IDLE), bit1 FULL, bit2 EMPTY, bit3 OVF (sticky), bits[7:4] COUNT. Reset value 32'h4.
  - Any write to STATUS clears OVF.
- **FIFO push/pop rules:**
  - A push while FULL is dropped and sets OVF.
  - A push and a pop in the same cycle while FULL: the pop frees a slot and the push is accepted. No OVF.
  - A push and a pop in the same cycle while EMPTY are not possible, because a pop requires a registered non-empty flag.
- **FSM states:** IDLE, START, DATA, STOP.
  - IDLE→START when EN=1 and the FIFO is not empty. This pops the head into an 8-bit shift register, loads the baud counter, and sets `TxD`=0.
  - START→DATA after one bit period; `TxD` = shift[0].
  - DATA: at each bit boundary, shift right and increment the 3-bit bit counter. After the 8th data bit, go to STOP with `TxD`=1.
  - STOP end: go to START with an immediate pop if EN=1 and the FIFO is not empty (no idle gap). Otherwise go to IDLE.
- **Data order:** LSB first.
- **EN=0 mid-frame:** the current frame completes. No new frame starts and FIFO contents are kept.
- **DIV write mid-frame:** the baud counter reloads from DIV at each bit boundary, so the new period applies from the next bit.
- **Interrupt:** `Out` = IE & EMPTY & (state == IDLE), registered one cycle.
- **Counters:** the baud counter is 16 bits and counts down to 1. The FIFO pointers wrap modulo DEPTH. COUNT saturates at DEPTH and is never exceeded.

## Timing
- **Reset values:**
  - `TxD`=1, `Out`=0, state IDLE, FIFO empty, OVF=0.
  - `DOut` per the register reset values above.
- **Latency:** with EN=1 and IDLE, a TXDATA write captured at edge N drives `TxD`=0 from edge N+1.
- **Frame length:** each bit lasts exactly P = max(DIV, 2) cycles; a frame is 10·P cycles.
- **Back-to-back frames:** the next start bit begins on the edge that ends the stop bit.
- **Status visibility:** FULL, EMPTY and COUNT update on the edge after the push or pop. BUSY changes on the same edge as the state.
- **Reset mid-frame:** `TxD` returns to 1 immediately (asynchronous). The FIFO is flushed and the frame is truncated.

## Configuration
- `COCO_UART_FIFO_EN` defined: the TX buffer is a DEPTH-entry circular FIFO.
- Undefined: the buffer is a single holding register and `DEPTH` is ignored.
  - COUNT ∈ {0,1}.
  - FULL = ~EMPTY.
  - A second write before the pop sets OVF and is dropped.
- All register addresses, bits and timing are otherwise identical.

## Test plan
- **Reset:** with `Reset`=0, check `TxD`=1, `Out`=0, and `DOut` for A=1 is 434, A=3 is 32'h4, A=0 is 0.
- **Single frame:** BAUD=4, CTRL=1, write 0x55. `TxD` goes 0,1,0,1,0,1,0,1,0,1, each level for 4 cycles, with the start bit one cycle after the write. BUSY=1 for 40 cycles, then 0.
- **Back-to-back frames (macro on, DEPTH=4):** BAUD=2, write 0xA1,0xB2,0xC3 with EN=0, then set EN=1. Expect three contiguous 20-cycle frames with no idle between them; COUNT reads 3, then 2, 1, 0.
- **Overflow:** EN=0, write 5 bytes (macro on, DEPTH=4). Expect STATUS = FULL, OVF, COUNT=4 (32'h4A). After a write to STATUS, OVF=0.
- **Interrupt:** CTRL=3, BAUD=2, write 0xFF. `Out` drops to 0 the cycle after the push and rises 1 cycle after the FSM returns to IDLE. Then CTRL=1 forces `Out`=0.
- **Mid-frame events:**
  - Clear EN during the 3rd data bit: the frame finishes, then the FSM goes IDLE with the remaining byte still queued.
  - Change BAUD 4→8 mid-frame: the new period starts at the next bit.
  - Pulse `Reset` low mid-frame: `TxD`=1 asynchronously and STATUS=32'h4.
